fma_norm_round: RTL

- Back end of the half-precision FMA datapath: consumes the aligned sum magnitude produced after the addend-alignment and add stages, and normalizes it.
- Normalization is iterative: right shift on carry-out or underflow, left shift (coarse or fine) on cancellation.
- The normalized value is rounded to binary16 (RNE or RZ) and the 16-bit result is presented with flags.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/fma_norm_round_if.sv | 35 +++
 rtl/fma_norm_round.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fma_norm_round_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fma_norm_round_if
// Purpose  : Operand / result handshake bundle for the FMA normalize-round stage
// Revision : 1.0 - initial release
// ============================================================================
interface fma_norm_round_if #(
    parameter int MW = 36,
    parameter int EW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [EW-1:0] in_exp;
    logic [MW-1:0] in_mant;
    logic          in_sticky;
    logic          in_rz;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_result;
    logic          out_overflow;
    logic          out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_sticky, in_rz, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_rz, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_inexact
    );
endinterface
`default_nettype wire

// File: rtl/fma_norm_round.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fma_norm_round
// Purpose  : Iterative normalizer and binary16 rounder (RNE/RZ) for the FMA back end
// Revision : 1.0 - initial release
// ============================================================================
module fma_norm_round #(
    parameter int MW     = 36,
    parameter int EW     = 7,
    parameter int COARSE = 8
) (
    input wire              clk,
    input wire              rst_n,
    fma_norm_round_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam int c_lead = MW - 3;
    localparam logic signed [EW-1:0] c_one      = EW'(1);
    localparam logic signed [EW-1:0] c_fine_lim = EW'(-7);
    localparam logic signed [EW-1:0] c_clamp    = EW'(-40);
    localparam logic signed [EW-1:0] c_coarse   = EW'(COARSE);
    localparam logic signed [EW-1:0] c_e31      = EW'(31);
    localparam logic signed [EW-1:0] c_emax     = {1'b0, {(EW-1){1'b1}}};

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [15:0]           r_result;
    logic                  r_overflow;
    logic                  r_inexact;
    logic                  r_sign;
    logic signed [EW-1:0]  r_exp;
    logic [MW-1:0]         r_mant;
    logic                  r_sticky;
    logic                  r_rz;

    logic [MW-1:0]         w_mant_nx;
    logic signed [EW-1:0]  w_exp_nx;
    logic                  w_stk_nx;
    logic                  w_norm_done;

    // One normalization step per cycle; the first matching rule wins.
    always_comb begin
        w_mant_nx   = r_mant;
        w_exp_nx    = r_exp;
        w_stk_nx    = r_sticky;
        w_norm_done = 1'b0;
        if (|r_mant[MW-1:MW-2]) begin
            w_mant_nx = r_mant >> 1;
            // Saturate instead of wrapping; any exponent this large overflows anyway.
            w_exp_nx  = (r_exp == c_emax) ? r_exp : r_exp + c_one;
            w_stk_nx  = r_sticky | r_mant[0];
        end else if (r_exp < c_one) begin
            if (r_exp < c_clamp) begin
                w_mant_nx = '0;
                w_exp_nx  = c_one;
                w_stk_nx  = r_sticky | (|r_mant);
            end else if (r_exp <= c_fine_lim) begin
                w_mant_nx = r_mant >> COARSE;
                w_exp_nx  = r_exp + c_coarse;
                w_stk_nx  = r_sticky | (|r_mant[COARSE-1:0]);
            end else begin
                w_mant_nx = r_mant >> 1;
                w_exp_nx  = r_exp + c_one;
                w_stk_nx  = r_sticky | r_mant[0];
            end
        end else if ((|r_mant) && !r_mant[c_lead] && (r_exp > c_one)) begin
            if (!(|r_mant[c_lead -: COARSE]) && (r_exp > c_coarse)) begin
                w_mant_nx = r_mant << COARSE;
                w_exp_nx  = r_exp - c_coarse;
            end else begin
                w_mant_nx = r_mant << 1;
                w_exp_nx  = r_exp - c_one;
            end
        end else begin
            w_norm_done = 1'b1;
        end
    end

    logic        w_g;
    logic        w_s;
    logic        w_inc;
    logic [4:0]  w_efield;
    logic [14:0] w_base;
    logic [14:0] w_sum;
    logic        w_ovf;
    logic [15:0] w_result;
    logic        w_inexact;

    // Rounding adds into the packed {exponent, fraction} so a fraction carry bumps the binade.
    always_comb begin
        w_g       = r_mant[c_lead-11];
        w_s       = (|r_mant[c_lead-12:0]) | r_sticky;
        w_inc     = ~r_rz & w_g & (r_mant[c_lead-10] | w_s);
        w_efield  = r_mant[c_lead] ? r_exp[4:0] : 5'd0;
        w_base    = {w_efield, r_mant[c_lead-1 -: 10]};
        w_sum     = w_base + {14'd0, w_inc};
        w_ovf     = (r_mant[c_lead] && (r_exp >= c_e31)) || (w_sum[14:10] == 5'h1F);
        w_result  = w_ovf ? {r_sign, (r_rz ? 15'h7BFF : 15'h7C00)} : {r_sign, w_sum};
        w_inexact = w_g | w_s | w_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 16'd0;
            r_overflow  <= 1'b0;
            r_inexact   <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_sticky    <= 1'b0;
            r_rz        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign     <= bus.in_sign;
                        r_exp      <= $signed(bus.in_exp);
                        r_mant     <= bus.in_mant;
                        r_sticky   <= bus.in_sticky;
                        r_rz       <= bus.in_rz;
                        r_in_ready <= 1'b0;
                        r_state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (w_norm_done) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_mant   <= w_mant_nx;
                        r_exp    <= w_exp_nx;
                        r_sticky <= w_stk_nx;
                    end
                end
                S_ROUND: begin
                    r_result    <= w_result;
                    r_overflow  <= w_ovf;
                    r_inexact   <= w_inexact;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_result   = r_result;
    assign bus.out_overflow = r_overflow;
    assign bus.out_inexact  = r_inexact;
endmodule
`default_nettype wire
